// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the ALU command sequencer:
//   - opcode encodings (identical to the board ALU opcodes)
//   - sequencer state encoding
//   - queued command layout and width
//   - alu_result(): the single-cycle opcode results
// -----------------------------------------------------------------------------
package alu_seq_pkg;

  localparam int CMD_W = 7;

  localparam logic [2:0] OP_MUL   = 3'b000;
  localparam logic [2:0] OP_SHR   = 3'b001;
  localparam logic [2:0] OP_SHL   = 3'b010;
  localparam logic [2:0] OP_NZ    = 3'b011;
  localparam logic [2:0] OP_LOGIC = 3'b100;
  localparam logic [2:0] OP_ADD2  = 3'b101;
  localparam logic [2:0] OP_ADD   = 3'b110;
  localparam logic [2:0] OP_INC   = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] a;
  } cmd_t;

  // Result of every single-cycle opcode; b is the low nibble of the
  // accumulator. OP_MUL is handled by the shift-add sequence and yields 0 here.
  function automatic logic [7:0] alu_result(input logic [2:0] op,
                                            input logic [3:0] a,
                                            input logic [3:0] b);
    logic [4:0] sum5;
    logic [4:0] inc5;
    logic [7:0] b8;
    logic [7:0] res;
    sum5 = {1'b0, a} + {1'b0, b};
    inc5 = {1'b0, a} + 5'd1;
    b8   = {4'b0000, b};
    res  = 8'd0;
    case (op)
      OP_INC:          res = {3'b000, inc5};
      OP_ADD, OP_ADD2: res = {3'b000, sum5};
      OP_LOGIC:        res = {a | b, a ^ b};
      OP_NZ:           res = {7'd0, |(a | b)};
      OP_SHL:          res = b8 << a;   // shift by 8 or more empties the byte
      OP_SHR:          res = b8 >> a;
      default:         res = 8'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// -----------------------------------------------------------------------------
// cmd_fifo
// Synchronous first-word-fall-through FIFO holding queued commands.
// Ports:
//   clock, reset         rising-edge clock, synchronous active-high reset
//   push, wr_data        write request (ignored when full)
//   pop                  remove head (ignored when empty)
//   rd_data              current head entry, valid while !empty
//   full, empty, count   occupancy status
// The head is read asynchronously so a command pushed at one edge can be
// executed at the very next edge.
// -----------------------------------------------------------------------------
module cmd_fifo
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int WIDTH = CMD_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;   // no pass-through when full, even on a pop
  assign pop_ok  = pop && !empty;
  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers wrap naturally since DEPTH is a power of two.
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only observed when count says so.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
// Pops {opcode, A} commands from a small FIFO and executes them against an
// 8-bit accumulator. Single-cycle opcodes retire one per cycle; OP_MUL runs a
// 4-cycle shift-add of acc[3:0] * A.
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   step                    (only with ALU_SEQ_STEP_EN) pop enable in IDLE
//   cmd_valid/cmd_ready     command handshake, cmd_ready = !full
//   cmd_op, cmd_a           opcode and operand A
//   res_valid               one-cycle pulse after acc was updated by a command
//   acc                     accumulator register
//   busy                    multiply in progress or FIFO non-empty
//   fifo_count              queued entries
// Configuration macro: ALU_SEQ_STEP_EN adds the step input for single-stepping.
// -----------------------------------------------------------------------------
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clock,
  input  logic             reset,
`ifdef ALU_SEQ_STEP_EN
  input  logic             step,
`endif
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [3:0]       cmd_a,
  output logic             res_valid,
  output logic [7:0]       acc,
  output logic             busy,
  output logic [PTR_W:0]   fifo_count
);

  cmd_t           head;
  logic [CMD_W-1:0] head_bits;
  logic           fifo_full;
  logic           fifo_empty;
  logic           pop_gate;
  logic           pop;

  state_e         state_q, state_d;
  logic [7:0]     acc_q, acc_d;
  logic           res_valid_q, res_valid_d;
  logic [3:0]     mcand_q, mcand_d;
  logic [3:0]     mplier_q, mplier_d;
  logic [7:0]     product_q, product_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [7:0]     partial;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (cmd_valid),
    .wr_data ({cmd_op, cmd_a}),
    .pop     (pop),
    .rd_data (head_bits),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign head = cmd_t'(head_bits);

`ifdef ALU_SEQ_STEP_EN
  assign pop_gate = step;
`else
  assign pop_gate = 1'b1;
`endif

  // The multiply never pops; the next command waits at the head until IDLE.
  assign pop = (state_q == ST_IDLE) && !fifo_empty && pop_gate;

  assign partial = mplier_q[cnt_q] ? ({4'b0000, mcand_q} << cnt_q) : 8'd0;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    res_valid_d = 1'b0;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    product_d   = product_q;
    cnt_d       = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          if (head.op == OP_MUL) begin
            mcand_d   = acc_q[3:0];
            mplier_d  = head.a;
            product_d = 8'd0;
            cnt_d     = 2'd0;
            state_d   = ST_MUL;
          end else begin
            acc_d       = alu_result(head.op, head.a, acc_q[3:0]);
            res_valid_d = 1'b1;
          end
        end
      end
      ST_MUL: begin
        product_d = product_q + partial;
        cnt_d     = cnt_q + 1'b1;
        // Last iteration: retire straight from the adder output.
        if (cnt_q == 2'd3) begin
          acc_d       = product_d;
          res_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      acc_q       <= 8'd0;
      res_valid_q <= 1'b0;
      mcand_q     <= 4'd0;
      mplier_q    <= 4'd0;
      product_q   <= 8'd0;
      cnt_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      res_valid_q <= res_valid_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      product_q   <= product_d;
      cnt_q       <= cnt_d;
    end
  end

  assign acc       = acc_q;
  assign res_valid = res_valid_q;
  assign cmd_ready = !fifo_full;
  assign busy      = (state_q == ST_MUL) || (fifo_count != '0);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_sequencer
// Directed scenarios with hand-computed expectations for alu_cmd_sequencer.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// With ALU_SEQ_STEP_EN defined, the step port and its scenario are included.
// -----------------------------------------------------------------------------
module tb_alu_cmd_sequencer;

  logic       clock;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_a;
  logic       res_valid;
  logic [7:0] acc;
  logic       busy;
  logic [2:0] fifo_count;
`ifdef ALU_SEQ_STEP_EN
  logic       step;
`endif

  int checks;
  int failures;

  alu_cmd_sequencer #(.DEPTH(4), .PTR_W(2)) dut (
    .clock      (clock),
    .reset      (reset),
`ifdef ALU_SEQ_STEP_EN
    .step       (step),
`endif
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .res_valid  (res_valid),
    .acc        (acc),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Push one command and let it execute (single-cycle opcodes only).
  task automatic exec1(input logic [2:0] op, input logic [3:0] a);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a;
    tick;
    cmd_valid = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    tick;
    checks++; if (acc !== 8'h00) begin failures++; $display("FAIL reset_acc got=%h exp=00", acc); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
    $display("test_reset done acc=%h count=%0d", acc, fifo_count);
  endtask

  task automatic test_back_to_back;
    cmd_valid = 1'b1; cmd_op = 3'b111; cmd_a = 4'd5;
    tick;
    checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL b2b_count1 got=%0d exp=1", fifo_count); end
    cmd_op = 3'b110; cmd_a = 4'd9;
    tick;
    cmd_valid = 1'b0;
    checks++; if (acc !== 8'h06 || res_valid !== 1'b1) begin failures++; $display("FAIL b2b_inc got acc=%h rv=%b exp acc=06 rv=1", acc, res_valid); end
    tick;
    checks++; if (acc !== 8'h0F || res_valid !== 1'b1) begin failures++; $display("FAIL b2b_add got acc=%h rv=%b exp acc=0f rv=1", acc, res_valid); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL b2b_drain got=%0d exp=0", fifo_count); end
    tick;
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL b2b_rv_low got=%b exp=0", res_valid); end
    $display("test_back_to_back done acc=%h", acc);
  endtask

  task automatic test_multiply;
    exec1(3'b111, 4'd12);
    checks++; if (acc !== 8'h0D) begin failures++; $display("FAIL mul_setup got=%h exp=0d", acc); end
    cmd_valid = 1'b1; cmd_op = 3'b000; cmd_a = 4'hB;
    tick;
    cmd_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mul_busy_e0 got=%b exp=1", busy); end
    for (int i = 1; i <= 4; i++) begin
      tick;
      checks++;
      if (busy !== 1'b1 || res_valid !== 1'b0) begin
        failures++; $display("FAIL mul_wait_e%0d got busy=%b rv=%b exp busy=1 rv=0", i, busy, res_valid);
      end
    end
    tick;
    checks++; if (res_valid !== 1'b1 || acc !== 8'h8F) begin failures++; $display("FAIL mul_result got acc=%h rv=%b exp acc=8f rv=1", acc, res_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mul_busy_end got=%b exp=0", busy); end
    $display("test_multiply done acc=%h", acc);
  endtask

  task automatic test_full;
    // acc=0x8F so the multiply computes 0xF * 1 while the FIFO fills.
    cmd_valid = 1'b1; cmd_op = 3'b000; cmd_a = 4'd1;
    tick;
    for (int i = 0; i < 4; i++) begin
      cmd_op = 3'b111; cmd_a = 4'(i);
      tick;
    end
    checks++; if (fifo_count !== 3'd4 || cmd_ready !== 1'b0) begin failures++; $display("FAIL full_state got cnt=%0d rdy=%b exp cnt=4 rdy=0", fifo_count, cmd_ready); end
    cmd_op = 3'b111; cmd_a = 4'd7;
    tick;
    cmd_valid = 1'b0;
    checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL full_drop got=%0d exp=4", fifo_count); end
    checks++; if (acc !== 8'h0F || res_valid !== 1'b1) begin failures++; $display("FAIL full_mul got acc=%h rv=%b exp acc=0f rv=1", acc, res_valid); end
    tick;
    checks++; if (fifo_count !== 3'd3 || cmd_ready !== 1'b1 || acc !== 8'h01) begin failures++; $display("FAIL full_pop got cnt=%0d rdy=%b acc=%h exp cnt=3 rdy=1 acc=01", fifo_count, cmd_ready, acc); end
    tick; tick; tick;
    checks++; if (acc !== 8'h04 || fifo_count !== 3'd0) begin failures++; $display("FAIL full_drain got acc=%h cnt=%0d exp acc=04 cnt=0", acc, fifo_count); end
    tick;
    checks++; if (acc !== 8'h04 || res_valid !== 1'b0) begin failures++; $display("FAIL full_no_fifth got acc=%h rv=%b exp acc=04 rv=0", acc, res_valid); end
    $display("test_full done acc=%h", acc);
  endtask

  task automatic test_ops;
    exec1(3'b111, 4'd14);
    exec1(3'b010, 4'd4);
    checks++; if (acc !== 8'hF0) begin failures++; $display("FAIL shl4 got=%h exp=f0", acc); end
    exec1(3'b111, 4'd14);
    exec1(3'b010, 4'd9);
    checks++; if (acc !== 8'h00) begin failures++; $display("FAIL shl9 got=%h exp=00", acc); end
    exec1(3'b111, 4'd2);
    exec1(3'b100, 4'h6);
    checks++; if (acc !== 8'h75) begin failures++; $display("FAIL logic got=%h exp=75", acc); end
    exec1(3'b001, 4'd1);
    checks++; if (acc !== 8'h02) begin failures++; $display("FAIL shr got=%h exp=02", acc); end
    exec1(3'b011, 4'd0);
    checks++; if (acc !== 8'h01) begin failures++; $display("FAIL nz_one got=%h exp=01", acc); end
    exec1(3'b001, 4'd4);
    exec1(3'b011, 4'd0);
    checks++; if (acc !== 8'h00) begin failures++; $display("FAIL nz_zero got=%h exp=00", acc); end
    exec1(3'b101, 4'hF);
    checks++; if (acc !== 8'h0F) begin failures++; $display("FAIL add2_a got=%h exp=0f", acc); end
    exec1(3'b101, 4'hF);
    checks++; if (acc !== 8'h1E) begin failures++; $display("FAIL add2_carry got=%h exp=1e", acc); end
    $display("test_ops done acc=%h", acc);
  endtask

  task automatic test_reset_mid_mul;
    cmd_valid = 1'b1; cmd_op = 3'b000; cmd_a = 4'd3;
    tick;
    cmd_op = 3'b111; cmd_a = 4'd1;
    tick;
    cmd_valid = 1'b0;
    tick;
    checks++; if (busy !== 1'b1 || fifo_count !== 3'd1) begin failures++; $display("FAIL midmul_pre got busy=%b cnt=%0d exp busy=1 cnt=1", busy, fifo_count); end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checks++; if (acc !== 8'h00 || res_valid !== 1'b0) begin failures++; $display("FAIL midmul_reset got acc=%h rv=%b exp acc=00 rv=0", acc, res_valid); end
    checks++; if (fifo_count !== 3'd0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL midmul_fifo got cnt=%0d busy=%b rdy=%b exp 0/0/1", fifo_count, busy, cmd_ready); end
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++;
      if (res_valid !== 1'b0 || acc !== 8'h00) begin
        failures++; $display("FAIL midmul_abort_c%0d got acc=%h rv=%b exp acc=00 rv=0", i, acc, res_valid);
      end
    end
    $display("test_reset_mid_mul done acc=%h", acc);
  endtask

`ifdef ALU_SEQ_STEP_EN
  task automatic test_step;
    step = 1'b0;
    cmd_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cmd_op = 3'b111; cmd_a = 4'(i);
      tick;
    end
    cmd_valid = 1'b0;
    checks++; if (fifo_count !== 3'd3) begin failures++; $display("FAIL step_queued got=%0d exp=3", fifo_count); end
    for (int i = 0; i < 10; i++) begin
      tick;
      checks++;
      if (acc !== 8'h00 || res_valid !== 1'b0) begin
        failures++; $display("FAIL step_hold_c%0d got acc=%h rv=%b exp acc=00 rv=0", i, acc, res_valid);
      end
    end
    step = 1'b1;
    tick;
    step = 1'b0;
    checks++; if (fifo_count !== 3'd2 || acc !== 8'h02 || res_valid !== 1'b1) begin failures++; $display("FAIL step_one got cnt=%0d acc=%h rv=%b exp cnt=2 acc=02 rv=1", fifo_count, acc, res_valid); end
    tick;
    checks++; if (fifo_count !== 3'd2 || acc !== 8'h02 || res_valid !== 1'b0) begin failures++; $display("FAIL step_stop got cnt=%0d acc=%h rv=%b exp cnt=2 acc=02 rv=0", fifo_count, acc, res_valid); end
    step = 1'b1;
    tick; tick;
    checks++; if (fifo_count !== 3'd0 || acc !== 8'h04) begin failures++; $display("FAIL step_run got cnt=%0d acc=%h exp cnt=0 acc=04", fifo_count, acc); end
    $display("test_step done acc=%h", acc);
  endtask
`endif

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'b000;
    cmd_a     = 4'd0;
`ifdef ALU_SEQ_STEP_EN
    step      = 1'b1;
`endif
    test_reset;
    test_back_to_back;
    test_multiply;
    test_full;
    test_ops;
    test_reset_mid_mul;
`ifdef ALU_SEQ_STEP_EN
    test_step;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Command-queue controller that sequences the lab ALU-plus-accumulator datapath.
- Requesters push {opcode, operand A} commands into a small FIFO. The sequencer pops commands in order and executes each against an internal 8-bit accumulator.
- The opcode encodings are the same as the board ALU's opcodes.
- Single-cycle ops execute back-to-back. Multiply runs as a 4-cycle shift-add sub-sequence, replacing the combinational multiplier.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, 2..16.
- PTR_W, 2, log2(DEPTH).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered this cycle.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_op  in  3  opcode (encodings below).
- cmd_a  in  4  operand A.
- res_valid  out  1  one-cycle pulse: acc updated by the last completed command.
- acc  out  8  accumulator value (register q).
- busy  out  1  high while a multiply is in progress or the FIFO is non-empty.
- fifo_count  out  PTR_W+1  number of entries queued.

Behaviour:
- Reset (synchronous, active-high, dominates all inputs):
  - acc=0, res_valid=0, FIFO emptied (fifo_count=0), state=IDLE.
  - Any in-flight multiply is aborted with no result.
- Push rule:
  - A command is written on an edge where cmd_valid && cmd_ready.
  - When full, cmd_ready=0 even if a pop occurs in the same cycle; there is no pass-through.
  - Push and pop in the same cycle on a non-full FIFO leaves fifo_count unchanged. Pointers wrap modulo DEPTH.
- States are IDLE and MUL.
- IDLE, FIFO non-empty:
  - Head is popped on the next edge.
  - Non-multiply op: acc <= result at that edge and res_valid=1 for the following cycle. Throughput is 1 command/cycle.
  - Opcode 000: latch mcand=acc[3:0], mplier=A, product=0, cnt=0; state goes to MUL. No res_valid.
- IDLE, FIFO empty: hold. res_valid=0.
- MUL, each edge:
  - if mplier[cnt], product += mcand<<cnt; cnt++.
  - On the edge where cnt==3: acc <= final product, res_valid pulses, state goes to IDLE.
  - No pop occurs while in MUL.
  - Latency: push at edge k, single-cycle result at edge k+1, multiply result at edge k+5.
- Opcode results (B = acc[3:0], all 8-bit, zero-extended):
  - 111: A+1 as a 5-bit sum.
  - 110: A+B as a 5-bit sum with carry in bit 4.
  - 101: A+B, same as 110.
  - 100: {A|B, A^B}.
  - 011: 8'd1 if (A|B)!=0, else 0.
  - 010: B<<A, truncated to 8 bits; A>=8 gives 0.
  - 001: B>>A.
  - 000: A*B via MUL.
- busy = (state==MUL) || (fifo_count!=0).

Optional Feature:
- Macro ALU_SEQ_STEP_EN.
- Defined:
  - Adds input port step (1 bit).
  - In IDLE, a pop occurs only on an edge where step=1 and the FIFO is non-empty. Holding step=1 gives free-run.
  - MUL iterations do not wait for step.
- Undefined: no step port; pops occur whenever the FIFO is non-empty.

Decomposition:
- Shared package alu_seq_pkg:
  - opcode localparams OP_MUL=3'b000 .. OP_INC=3'b111;
  - state encoding ST_IDLE, ST_MUL;
  - command struct/width constant CMD_W=7.
- One natural sub-module: cmd_fifo, a synchronous FIFO with DEPTH/PTR_W parameters, push/pop, full/empty and count.

Test Plan:
- Reset then idle: acc=0, cmd_ready=1, busy=0, fifo_count=0. Assert reset mid-MUL (op 000 in flight): next cycle acc=0, no res_valid, FIFO empty.
- Push 111,A=5 then 110,A=9 on consecutive cycles: acc=6 one cycle later with res_valid, then acc=0x0F; res_valid high 2 consecutive cycles.
- With acc=0x0D, push op 000,A=0xB: res_valid exactly 5 edges after the push; acc=0x8F (13*11=143); busy high throughout.
- Hold with a multiply queued, then fill DEPTH=4 entries: cmd_ready=0, a fifth push is ignored (fifo_count stays 4). After a pop, cmd_ready=1.
- Op 010 with B=0xF, A=4 gives acc=0xF0; then op 010 with A=9 gives 0x00. Op 100 with A=0x6, B=0x3 gives 0x75.
- ALU_SEQ_STEP_EN defined: queue 3 commands with step=0, and acc is unchanged for 10 cycles. Pulse step once: exactly one command executes and fifo_count drops by 1.
